// File: rtl/key_led_ctrl.sv
// Key-driven LED mode controller: synchronises and debounces an active-low key,
// steps OFF -> ON -> SLOW -> FAST on each accepted press and drives the LED from the mode.
module key_led_ctrl #(
   parameter int unsigned DEB_CYC   = 1_000_000,
   parameter int unsigned SLOW_HALF = 25_000_000,
   parameter int unsigned FAST_HALF = 5_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_in,
   output logic       led_out,
   output logic [1:0] mode,
   output logic       key_flag
);

   localparam int unsigned DEB_W    = $clog2(DEB_CYC);
   localparam int unsigned MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int unsigned BLK_W    = $clog2(MAX_HALF);

   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [BLK_W-1:0] SLOW_LAST = BLK_W'(SLOW_HALF - 1);
   localparam logic [BLK_W-1:0] FAST_LAST = BLK_W'(FAST_HALF - 1);

   typedef enum logic [1:0] {
      StOff  = 2'd0,
      StOn   = 2'd1,
      StSlow = 2'd2,
      StFast = 2'd3
   } mode_e;

   logic             r_key_s1;
   logic             r_key_sync;
   logic             r_key_stable;
   logic [DEB_W-1:0] r_deb_cnt;
   logic             r_key_flag;
   mode_e            r_mode;
   mode_e            w_mode_d;
   logic [BLK_W-1:0] r_blink_cnt;
   logic             r_phase;
   logic [BLK_W-1:0] w_half_last;
   logic             r_led;
   logic             w_led_d;

   // Two-flop synchroniser; idles high because the key is active-low.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_key_s1   <= 1'b1;
         r_key_sync <= 1'b1;
      end else begin
         r_key_s1   <= key_in;
         r_key_sync <= r_key_s1;
      end
   end

   // Any bounce back to the stable level restarts the count.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_key_stable <= 1'b1;
         r_deb_cnt    <= '0;
         r_key_flag   <= 1'b0;
      end else begin
         r_key_flag <= 1'b0;
         if (r_key_sync == r_key_stable) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == DEB_LAST) begin
            r_key_stable <= r_key_sync;
            r_deb_cnt    <= '0;
            r_key_flag   <= ~r_key_sync;
         end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_mode <= StOff;
      end else begin
         r_mode <= w_mode_d;
      end
   end

   always_comb begin
      w_mode_d = r_mode;
      if (r_key_flag) begin
         unique case (r_mode)
            StOff:  w_mode_d = StOn;
            StOn:   w_mode_d = StSlow;
            StSlow: w_mode_d = StFast;
            StFast: w_mode_d = StOff;
         endcase
      end
   end

   assign w_half_last = (r_mode == StSlow) ? SLOW_LAST : FAST_LAST;

   // Blink restarts lit on every mode change so each lit interval is a full half-period.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if ((w_mode_d != r_mode) || (r_mode == StOff) || (r_mode == StOn)) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (r_blink_cnt == w_half_last) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
   end

   always_comb begin
      w_led_d = 1'b0;
      unique case (r_mode)
         StOff:  w_led_d = 1'b0;
         StOn:   w_led_d = 1'b1;
         StSlow: w_led_d = r_phase;
         StFast: w_led_d = r_phase;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_led <= 1'b0;
      end else begin
         r_led <= w_led_d;
      end
   end

   assign led_out  = r_led;
   assign mode     = r_mode;
   assign key_flag = r_key_flag;

endmodule
